// File: rtl/btn_event_decoder.sv
// btn_event_decoder: classifies debounced button gestures into short press,
// long press and double click. Each gesture produces one registered pulse.
// HELD stays high for as long as a long press is held.
module btn_event_decoder #(
    parameter int unsigned LONG_CYCLES   = 100_000_000,
    parameter int unsigned DCLICK_CYCLES = 30_000_000,
    parameter int unsigned CNT_W         = 27
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN_DBOUN,
    output logic SHORT_P,
    output logic LONG_P,
    output logic DOUBLE_P,
    output logic HELD
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS1,
        S_LONG_HOLD,
        S_WAIT2,
        S_PRESS2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LIM   = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] DCLICK_LIM = CNT_W'(DCLICK_CYCLES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_q;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             double_q, double_d;
    logic             held_q, held_d;

    logic             rise, fall;
    logic [CNT_W-1:0] cnt_inc;

    // Edge detection and a saturating increment shared by the counting states
    always_comb begin
        rise    = BTN_DBOUN & ~btn_q;
        fall    = ~BTN_DBOUN & btn_q;
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end

    // Next-state, counter and registered-output decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        held_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_PRESS1;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_PRESS1: begin
                if (fall) begin
                    state_d = S_WAIT2;
                    cnt_d   = '0;
                end else if (BTN_DBOUN) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == LONG_LIM) begin
                        long_d  = 1'b1;
                        held_d  = 1'b1;
                        state_d = S_LONG_HOLD;
                    end
                end
            end
            S_LONG_HOLD: begin
                if (fall) begin
                    state_d = S_IDLE;
                end else begin
                    held_d = 1'b1;
                end
            end
            S_WAIT2: begin
                // A rise on the expiry edge still counts as the second click
                if (rise) begin
                    state_d = S_PRESS2;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DCLICK_LIM) begin
                        short_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_PRESS2: begin
                if (fall) begin
                    double_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter, previous-sample and output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            btn_q    <= 1'b1;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            btn_q    <= BTN_DBOUN;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
            held_q   <= held_d;
        end
    end

    assign SHORT_P  = short_q;
    assign LONG_P   = long_q;
    assign DOUBLE_P = double_q;
    assign HELD     = held_q;

endmodule

// File: doc/btn_event_decoder.md
Name: btn_event_decoder

Overview:
- Consumer end of the synchronous button debouncer. Takes the clean debounced level, BTN_DBOUN, which is synchronous to CLK.
- Classifies each gesture as a short press, a long press or a double click.
- Emits one single-cycle pulse per gesture. Also provides a level that is high while a long press is held.
- Sits between the debouncer and the application logic on the Arty A7-35T at 100 MHz.

Parameters:
- LONG_CYCLES, 100_000_000, consecutive high samples that qualify a long press (1 s). Must be >= 2.
- DCLICK_CYCLES, 30_000_000, maximum low gap, in cycles, between first release and second press for a double click (300 ms). Must be >= 2.
- CNT_W, 27, counter width. Must satisfy 2^CNT_W > max(LONG_CYCLES, DCLICK_CYCLES).

Ports:
- CLK  in  1  system clock, 100 MHz.
- RST_N  in  1  asynchronous, active-low reset.
- BTN_DBOUN  in  1  debounced button level, synchronous to CLK, 1 = pressed.
- SHORT_P  out  1  one-cycle pulse: single short press completed.
- LONG_P  out  1  one-cycle pulse: press held for LONG_CYCLES.
- DOUBLE_P  out  1  one-cycle pulse: double click completed.
- HELD  out  1  high while in long-hold state.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE, counter = 0, all outputs = 0.
  - Previous-sample register btn_q = 1. A button already held across reset release is ignored until it is released and pressed again.
- Edge detection: rise = BTN_DBOUN & ~btn_q; fall = ~BTN_DBOUN & btn_q. btn_q updates every edge.
- All outputs are registered. A pulse is high exactly one cycle, in the cycle after the deciding edge.
- States:
  - IDLE: on rise -> PRESS1, cnt = 1. Otherwise stay.
  - PRESS1:
    - While BTN_DBOUN = 1, cnt++.
    - When cnt reaches LONG_CYCLES -> LONG_P = 1, HELD = 1, go to LONG_HOLD.
    - On fall before that -> WAIT2, cnt = 0.
  - LONG_HOLD:
    - HELD stays 1. On fall -> HELD = 0, IDLE.
    - No SHORT_P and no DOUBLE_P are ever produced for this press.
  - WAIT2:
    - cnt++ each cycle.
    - On rise -> PRESS2.
    - When cnt reaches DCLICK_CYCLES with no rise -> SHORT_P = 1, IDLE.
    - If rise and expiry occur on the same edge, rise wins (-> PRESS2, no SHORT_P).
  - PRESS2:
    - On fall -> DOUBLE_P = 1, IDLE, regardless of how long the second press lasted.
    - The counter is not used in this state; it holds (saturates) rather than wrapping.
- SHORT_P latency: DCLICK_CYCLES + 1 cycles after the first fall. This delay is inherent, because the block must rule out a double click first.
- At most one of SHORT_P, LONG_P, DOUBLE_P is high in any cycle.
- Counter never wraps. It is cleared on every state entry that uses it.
- Reset asserted mid-gesture aborts the gesture. No pulse is emitted, and HELD drops immediately.
- Every state only reacts to edges of BTN_DBOUN, so a glitch-free input is required; this is the debouncer's job.

Test Plan:
All scenarios use LONG_CYCLES = 20, DCLICK_CYCLES = 10, CNT_W = 8.
- Single short press: BTN high 5 cycles, then low. -> One SHORT_P pulse 11 cycles after the fall. LONG_P = DOUBLE_P = HELD = 0 throughout.
- Long press: BTN high 40 cycles. -> LONG_P pulses once, one cycle after the 20th high sample. HELD = 1 from that cycle until one cycle after the fall. No SHORT_P after release.
- Double click: high 5, low 4, high 5, low. -> DOUBLE_P pulses one cycle after the second fall. No SHORT_P.
- Gap boundary:
  - Low gap of exactly 10 cycles with the rise on the expiry edge -> DOUBLE_P, no SHORT_P.
  - Gap of 11 cycles -> SHORT_P, then the second press is decoded as a new gesture.
- Reset with button held: RST_N low with BTN = 1, release reset while BTN stays high for 30 cycles, then low. -> No LONG_P, HELD = 0, no pulses at all. The next press decodes normally.
- Reset mid-long-hold: assert RST_N while HELD = 1. -> HELD and all pulses go to 0 asynchronously. After release and BTN low, state is IDLE.
